// File: rtl/mem_data_bridge.sv
// mem_data_bridge
//   Converts the core's single-cycle data SRAM access into a
//   variable-latency req/addr_ok/data_ok memory bus transaction. It stalls
//   the core until the access completes, then holds read data stable for
//   the MEM stage until the pipeline advances.
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-low reset
//   data_sram_en/wen/addr/wdata   core access request (wen==0 is a read)
//   data_sram_rdata     read word returned to the MEM stage
//   stallreq            stall request to the core (combinational in IDLE)
//   core_stall          core pipeline is not advancing this cycle
//   bus_req/wr/size/wstrb/addr/wdata   bus request channel
//   bus_addr_ok         request accepted by the bus
//   bus_data_ok/rdata   response channel
//   state_dbg           current FSM state: 0 IDLE, 1 REQ, 2 WAIT, 3 HOLD
//
// Handshake: a request is in flight on every cycle bus_req=1; it is
// transferred on the rising edge where bus_req=1 and bus_addr_ok=1. The
// single response is transferred on the first later rising edge where
// bus_data_ok=1. bus_data_ok outside WAIT is ignored.
module mem_data_bridge #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  data_sram_en,
  input  logic [3:0]            data_sram_wen,
  input  logic [ADDR_WIDTH-1:0] data_sram_addr,
  input  logic [DATA_WIDTH-1:0] data_sram_wdata,
  output logic [DATA_WIDTH-1:0] data_sram_rdata,
  output logic                  stallreq,
  input  logic                  core_stall,
  output logic                  bus_req,
  output logic                  bus_wr,
  output logic [1:0]            bus_size,
  output logic [3:0]            bus_wstrb,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [DATA_WIDTH-1:0] bus_wdata,
  input  logic                  bus_addr_ok,
  input  logic                  bus_data_ok,
  input  logic [DATA_WIDTH-1:0] bus_rdata,
  output logic [1:0]            state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t state;

  logic                  is_write;
  logic [1:0]            req_size;
  logic [ADDR_WIDTH-1:0] req_addr;

  // Request fields derived from the core's access, latched on acceptance.
  // Irregular write patterns fall back to a word access with the strobes
  // passed through unchanged.
  always_comb begin
    is_write = |data_sram_wen;
    req_size = 2'd2;
    req_addr = {data_sram_addr[ADDR_WIDTH-1:2], 2'b00};
    if (is_write) begin
      req_addr = data_sram_addr;
      unique case (data_sram_wen)
        4'b0001, 4'b0010, 4'b0100, 4'b1000: req_size = 2'd0;
        4'b0011, 4'b1100:                   req_size = 2'd1;
        default:                            req_size = 2'd2;
      endcase
    end
  end

  // In IDLE the stall must be raised in the same cycle the core presents
  // the access, so it cannot wait for the state register.
  always_comb begin
    stallreq = 1'b0;
    unique case (state)
      IDLE:    stallreq = data_sram_en;
      REQ:     stallreq = 1'b1;
      WAIT:    stallreq = 1'b1;
      default: stallreq = 1'b0;
    endcase
  end

  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= IDLE;
      bus_req         <= 1'b0;
      bus_wr          <= 1'b0;
      bus_size        <= 2'd0;
      bus_wstrb       <= 4'd0;
      bus_addr        <= '0;
      bus_wdata       <= '0;
      data_sram_rdata <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (data_sram_en) begin
            state     <= REQ;
            bus_req   <= 1'b1;
            bus_wr    <= is_write;
            bus_size  <= req_size;
            bus_wstrb <= data_sram_wen;
            bus_addr  <= req_addr;
            bus_wdata <= data_sram_wdata;
          end
        end
        REQ: begin
          if (bus_addr_ok) begin
            state   <= WAIT;
            bus_req <= 1'b0;
          end
        end
        WAIT: begin
          if (bus_data_ok) begin
            state <= HOLD;
            if (!bus_wr) data_sram_rdata <= bus_rdata;
          end
        end
        HOLD: begin
          // data_sram_en still belongs to the completed instruction here;
          // only the pipeline advancing releases the bridge.
          if (!core_stall) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_data_bridge.sv
// Self-checking bench for mem_data_bridge: directed scenarios followed by
// randomized accesses, compared against a transaction-level reference model.
module tb_mem_data_bridge;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        data_sram_en = 1'b0;
  logic [3:0]  data_sram_wen = 4'd0;
  logic [31:0] data_sram_addr = 32'd0;
  logic [31:0] data_sram_wdata = 32'd0;
  logic [31:0] data_sram_rdata;
  logic        stallreq;
  logic        core_stall = 1'b0;
  logic        bus_req;
  logic        bus_wr;
  logic [1:0]  bus_size;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_addr_ok = 1'b0;
  logic        bus_data_ok = 1'b0;
  logic [31:0] bus_rdata = 32'd0;
  logic [1:0]  state_dbg;

  mem_data_bridge dut (
    .clk(clk), .rst(rst),
    .data_sram_en(data_sram_en), .data_sram_wen(data_sram_wen),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .data_sram_rdata(data_sram_rdata), .stallreq(stallreq),
    .core_stall(core_stall), .bus_req(bus_req), .bus_wr(bus_wr),
    .bus_size(bus_size), .bus_wstrb(bus_wstrb), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_addr_ok(bus_addr_ok),
    .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata), .state_dbg(state_dbg)
  );

  // scoreboard
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];      // read data expected, in order of completion
  logic [31:0] exp_rdata = 32'd0;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  // reference model: bus fields for one core access
  function automatic logic [1:0] model_size(input logic [3:0] wen);
    int ones;
    ones = $countones(wen);
    if (wen == 4'd0) return 2'd2;
    if (ones == 1) return 2'd0;
    if (wen == 4'b0011 || wen == 4'b1100) return 2'd1;
    return 2'd2;
  endfunction

  function automatic logic [31:0] model_addr(input logic [3:0] wen,
                                             input logic [31:0] addr);
    if (wen == 4'd0) return addr - (addr % 4);
    return addr;
  endfunction

  task automatic check_outputs_idle(input string tag);
    check_eq({tag, ".state"}, {30'd0, state_dbg}, {30'd0, S_IDLE});
    check_eq({tag, ".stall"}, {31'd0, stallreq}, 32'd0);
    check_eq({tag, ".req"}, {31'd0, bus_req}, 32'd0);
    check_eq({tag, ".rdata"}, data_sram_rdata, exp_rdata);
  endtask

  // driver: one complete core access, with idle gap before it
  task automatic do_access(input logic [3:0] wen, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] rd,
                           input int a_dly, input int d_dly,
                           input int h_stall, input int gap);
    logic [31:0] e_addr;
    logic [1:0]  e_size;
    e_addr = model_addr(wen, addr);
    e_size = model_size(wen);
    // idle gap: wen without en and stray data_ok must be ignored
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      data_sram_en = 1'b0;
      data_sram_wen = 4'($urandom_range(0, 15));
      core_stall = 1'b0;
      bus_data_ok = 1'($urandom_range(0, 1));
      bus_rdata = $urandom;
      #1 check_outputs_idle("gap");
    end
    // IDLE acceptance cycle
    @(negedge clk);
    data_sram_en = 1'b1;
    data_sram_wen = wen;
    data_sram_addr = addr;
    data_sram_wdata = wdata;
    core_stall = 1'b1;
    bus_data_ok = 1'b0;
    #1;
    check_eq("acc.stall", {31'd0, stallreq}, 32'd1);
    check_eq("acc.req", {31'd0, bus_req}, 32'd0);
    // REQ: fields stable until accepted; data_ok here is ignored
    for (int i = 0; i <= a_dly; i++) begin
      @(negedge clk);
      data_sram_addr = $urandom;   // latched copy must not follow the core
      data_sram_wdata = $urandom;
      bus_addr_ok = (i == a_dly);
      bus_data_ok = 1'($urandom_range(0, 1));
      bus_rdata = $urandom;
      #1;
      check_eq("req.state", {30'd0, state_dbg}, {30'd0, S_REQ});
      check_eq("req.req", {31'd0, bus_req}, 32'd1);
      check_eq("req.stall", {31'd0, stallreq}, 32'd1);
      check_eq("req.wr", {31'd0, bus_wr}, {31'd0, wen != 4'd0});
      check_eq("req.size", {30'd0, bus_size}, {30'd0, e_size});
      check_eq("req.wstrb", {28'd0, bus_wstrb}, {28'd0, wen});
      check_eq("req.addr", bus_addr, e_addr);
      check_eq("req.wdata", bus_wdata, wdata);
    end
    // WAIT
    for (int j = 0; j <= d_dly; j++) begin
      @(negedge clk);
      bus_addr_ok = 1'b0;
      bus_data_ok = (j == d_dly);
      bus_rdata = (j == d_dly) ? rd : $urandom;
      #1;
      check_eq("wait.state", {30'd0, state_dbg}, {30'd0, S_WAIT});
      check_eq("wait.req", {31'd0, bus_req}, 32'd0);
      check_eq("wait.stall", {31'd0, stallreq}, 32'd1);
      check_eq("wait.rdata", data_sram_rdata, exp_rdata);
    end
    if (wen == 4'd0) exp_q.push_back(rd);
    // HOLD: en stays high for the same instruction
    for (int k = 0; k <= h_stall; k++) begin
      @(negedge clk);
      bus_data_ok = 1'b0;
      bus_rdata = $urandom;
      core_stall = (k < h_stall);
      if (k == 0 && wen == 4'd0) exp_rdata = exp_q.pop_front();
      #1;
      check_eq("hold.state", {30'd0, state_dbg}, {30'd0, S_HOLD});
      check_eq("hold.stall", {31'd0, stallreq}, 32'd0);
      check_eq("hold.req", {31'd0, bus_req}, 32'd0);
      check_eq("hold.rdata", data_sram_rdata, exp_rdata);
    end
  endtask

  logic [3:0] wen_tab[8];

  initial begin
    wen_tab = '{4'b0000, 4'b0000, 4'b1111, 4'b0011, 4'b1100, 4'b0100,
                4'b0101, 4'b0111};
    // reset state
    repeat (2) @(negedge clk);
    #1;
    check_eq("rst.state", {30'd0, state_dbg}, {30'd0, S_IDLE});
    check_eq("rst.stall", {31'd0, stallreq}, 32'd0);
    check_eq("rst.fields", {26'd0, bus_req, bus_wr, bus_size, bus_wstrb == 4'd0,
             bus_addr == 32'd0}, 32'd3);
    check_eq("rst.wdata", bus_wdata, 32'd0);
    check_eq("rst.rdata", data_sram_rdata, 32'd0);
    @(negedge clk) rst = 1'b1;

    // word read, minimum latency
    do_access(4'b0000, 32'h1000_0006, 32'd0, 32'hDEAD_BEEF, 0, 0, 0, 1);
    // byte write leaves rdata untouched
    do_access(4'b0100, 32'h0000_0020, 32'h00AB_0000, 32'h5555_5555, 0, 0, 0, 0);
    // slow bus
    do_access(4'b0000, 32'h0000_0104, 32'd0, 32'h0BAD_F00D, 4, 3, 0, 1);
    // HOLD with external stall
    do_access(4'b0000, 32'h0000_0200, 32'd0, 32'h1234_5678, 0, 0, 2, 0);
    // back-to-back loads
    do_access(4'b0000, 32'h0000_0300, 32'd0, 32'hAAAA_0001, 0, 0, 0, 0);
    do_access(4'b0000, 32'h0000_0303, 32'd0, 32'hBBBB_0002, 0, 0, 0, 0);

    // reset in WAIT, then a stray data_ok after release
    @(negedge clk);
    data_sram_en = 1'b1; data_sram_wen = 4'd0; data_sram_addr = 32'h40;
    core_stall = 1'b1;
    @(negedge clk) bus_addr_ok = 1'b1;
    @(negedge clk);
    bus_addr_ok = 1'b0;
    #1 check_eq("rw.state", {30'd0, state_dbg}, {30'd0, S_WAIT});
    @(negedge clk);
    rst = 1'b0; data_sram_en = 1'b0; core_stall = 1'b0;
    exp_rdata = 32'd0;
    #1;
    check_eq("rw.fields", {26'd0, bus_req, bus_wr, bus_size, bus_wstrb == 4'd0,
             bus_addr == 32'd0}, 32'd3);
    check_eq("rw.wdata", bus_wdata, 32'd0);
    check_outputs_idle("rw.rst");
    @(negedge clk) rst = 1'b1;
    @(negedge clk);
    bus_data_ok = 1'b1; bus_rdata = 32'hFEED_FACE;
    #1 check_outputs_idle("rw.stray");
    @(negedge clk) bus_data_ok = 1'b0;
    #1 check_outputs_idle("rw.after");

    // randomized accesses
    for (int n = 0; n < 60; n++) begin
      logic [3:0] w;
      w = wen_tab[$urandom_range(0, 7)];
      do_access(w, $urandom, $urandom, $urandom, $urandom_range(0, 3),
                $urandom_range(0, 3), $urandom_range(0, 2),
                $urandom_range(0, 2));
    end
    @(negedge clk);
    data_sram_en = 1'b0; core_stall = 1'b0;
    #1 check_outputs_idle("end");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
